cordic_unit: RTL and testbench

//  CVA6 functional unit computing single-precision sin(x) or cos(x) by an iterative rotation-mode CORDIC.

---
 rtl/cordic_pkg.sv | 64 ++++++
 rtl/cordic_stage.sv | 35 +++
 rtl/cordic_unit.sv | 214 +++++++++++++++++++++
 tb/tb_cordic_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and Q3.29 constants for the CORDIC sin/cos unit.
// Also holds the issue-side operation bundle seen by the unit.
package cordic_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [3:0] {
    NOP,
    ADD,
    SIN,
    COS
  } fu_op;

  typedef struct packed {
    fu_op                     operation;
    logic [XLEN-1:0]          operand_a;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    ITER,
    NORM
  } state_e;

  localparam logic signed [31:0] K_Q  = 32'sh136E_9DB5;
  localparam logic signed [31:0] PI_Q = 32'sh6487_ED51;
  localparam logic [31:0] HPI_Q  = 32'h3243_F6A9;
  // binary32(pi) lands just above pi; it must still count as in range
  localparam logic [31:0] PI_LIM = 32'h6487_ED80;

  localparam logic [31:0] F_ONE  = 32'h3F80_0000;
  localparam logic [31:0] F_QNAN = 32'h7FC0_0000;

  function automatic logic signed [31:0] atan_q(
    input logic [4:0] i
  );
    case (i)
      5'd0:    atan_q = 32'sh1921_FB54;
      5'd1:    atan_q = 32'sh0ED6_3383;
      5'd2:    atan_q = 32'sh07D6_DD7E;
      5'd3:    atan_q = 32'sh03FA_B753;
      5'd4:    atan_q = 32'sh01FF_55BB;
      5'd5:    atan_q = 32'sh00FF_EAAE;
      5'd6:    atan_q = 32'sh007F_FD55;
      5'd7:    atan_q = 32'sh003F_FFAB;
      5'd8:    atan_q = 32'sh001F_FFF5;
      5'd9:    atan_q = 32'sh000F_FFFF;
      default: atan_q = 32'h2000_0000 >> i;
    endcase
  endfunction

  function automatic logic [5:0] lzc32(
    input logic [31:0] v
  );
    lzc32 = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) lzc32 = 6'(31 - i);
    end
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational rotation-mode CORDIC micro-rotation.
// Shift index also selects the atan table entry.
module cordic_stage
  import cordic_pkg::*;
(
  input  logic signed [31:0] x_i,
  input  logic signed [31:0] y_i,
  input  logic signed [31:0] z_i,
  input  logic [4:0]         sh_i,
  output logic signed [31:0] x_o,
  output logic signed [31:0] y_o,
  output logic signed [31:0] z_o
);

  logic signed [31:0] xs;
  logic signed [31:0] ys;
  logic signed [31:0] at;

  assign xs = x_i >>> sh_i;
  assign ys = y_i >>> sh_i;
  assign at = atan_q(sh_i);

  always_comb begin
    if (!z_i[31]) begin
      x_o = x_i - ys;
      y_o = y_i + xs;
      z_o = z_i - at;
    end else begin
      x_o = x_i + ys;
      y_o = y_i - xs;
      z_o = z_i + at;
    end
  end

endmodule

// File: rtl/cordic_unit.sv
// Iterative CORDIC sin/cos functional unit, binary32 in and out.
// One operation in flight; result pulses with its trans_id.
module cordic_unit
  import cordic_pkg::*;
#(
  parameter int unsigned ITERATIONS     = 16,
  parameter int unsigned ITER_PER_CYCLE = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  fu_data_t                 fu_data_i,
  input  logic                     cordic_valid_i,
  output logic [XLEN-1:0]          result_o,
  output logic                     cordic_valid_o,
  output logic                     cordic_ready_o,
  output logic [TRANS_ID_BITS-1:0] cordic_trans_id_o
);

  localparam int unsigned NCYC = ITERATIONS / ITER_PER_CYCLE;
  localparam int unsigned CW = (NCYC > 1) ? $clog2(NCYC) : 1;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  fu_op op_q, op_d;
  logic [TRANS_ID_BITS-1:0] tid_q, tid_d;
  logic signed [31:0] x_q, x_d;
  logic signed [31:0] y_q, y_d;
  logic signed [31:0] z_q, z_d;
  logic fold_q, fold_d;
  logic spec_q, spec_d;
  logic unsup_q, unsup_d;
  logic [31:0] sres_q, sres_d;
  logic [XLEN-1:0] res_q, res_d;
  logic vld_q, vld_d;
  logic [TRANS_ID_BITS-1:0] tido_q, tido_d;

  logic unused_hi;
  assign unused_hi = ^fu_data_i.operand_a[XLEN-1:32];

  logic sgn;
  logic [7:0] ex;
  logic [23:0] man;
  logic [31:0] mag;
  logic cv_unsup;
  logic cv_fold;
  logic cv_spec;
  logic [31:0] cv_sres;
  logic signed [31:0] cv_z;

  always_comb begin
    sgn = a_q[31];
    ex = a_q[30:23];
    man = {1'b1, a_q[22:0]};
    if (ex >= 8'd121) mag = {8'b0, man} << (ex - 8'd121);
    else mag = {8'b0, man} >> (8'd121 - ex);
    cv_unsup = (op_q != SIN) && (op_q != COS);
    cv_fold = mag > HPI_Q;
    cv_spec = 1'b1;
    cv_sres = '0;
    if (cv_unsup) begin
      cv_sres = '0;
    end else if (ex == 8'd0) begin
      cv_sres = (op_q == SIN) ? {sgn, 31'b0} : F_ONE;
    end else if (ex >= 8'd129 || mag > PI_LIM) begin
      cv_sres = F_QNAN;
    end else begin
      cv_spec = 1'b0;
    end
    if (!cv_fold) cv_z = sgn ? -$signed(mag) : $signed(mag);
    else if (sgn) cv_z = $signed(mag) - PI_Q;
    else cv_z = PI_Q - $signed(mag);
  end

  logic signed [31:0] xc [ITER_PER_CYCLE+1];
  logic signed [31:0] yc [ITER_PER_CYCLE+1];
  logic signed [31:0] zc [ITER_PER_CYCLE+1];

  assign xc[0] = x_q;
  assign yc[0] = y_q;
  assign zc[0] = z_q;

  for (genvar k = 0; k < ITER_PER_CYCLE; k++) begin : g_rot
    logic [4:0] sh;
    assign sh = 5'(cnt_q * ITER_PER_CYCLE + k);
    cordic_stage u_stage (
      .x_i (xc[k]),
      .y_i (yc[k]),
      .z_i (zc[k]),
      .sh_i(sh),
      .x_o (xc[k+1]),
      .y_o (yc[k+1]),
      .z_o (zc[k+1])
    );
  end

  logic signed [31:0] v;
  logic [31:0] vm;
  logic [5:0] lz;
  logic [31:0] f32;

  always_comb begin
    if (op_q == SIN) v = y_q;
    else v = fold_q ? -x_q : x_q;
    vm = v[31] ? 32'(-v) : 32'(v);
    lz = lzc32(vm);
    if (vm == '0) f32 = '0;
    else f32 = {v[31], 8'd129 - {2'b0, lz}, 23'((vm << lz) >> 8)};
  end

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    op_d = op_q;
    tid_d = tid_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    fold_d = fold_q;
    spec_d = spec_q;
    unsup_d = unsup_q;
    sres_d = sres_q;
    res_d = res_q;
    vld_d = 1'b0;
    tido_d = tido_q;
    unique case (state_q)
      IDLE: begin
        if (cordic_valid_i) begin
          a_d = fu_data_i.operand_a[31:0];
          op_d = fu_data_i.operation;
          tid_d = fu_data_i.trans_id;
          state_d = CONV;
        end
      end
      CONV: begin
        x_d = K_Q;
        y_d = '0;
        z_d = cv_z;
        fold_d = cv_fold;
        spec_d = cv_spec;
        unsup_d = cv_unsup;
        sres_d = cv_sres;
        cnt_d = '0;
        state_d = ITER;
      end
      ITER: begin
        x_d = xc[ITER_PER_CYCLE];
        y_d = yc[ITER_PER_CYCLE];
        z_d = zc[ITER_PER_CYCLE];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NCYC - 1)) state_d = NORM;
      end
      NORM: begin
        vld_d = 1'b1;
        tido_d = tid_q;
        res_d = '1;
        res_d[31:0] = spec_q ? sres_q : f32;
        if (unsup_q) res_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      vld_d = 1'b0;
      res_d = res_q;
      tido_d = tido_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      op_q <= NOP;
      tid_q <= '0;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      fold_q <= 1'b0;
      spec_q <= 1'b0;
      unsup_q <= 1'b0;
      sres_q <= '0;
      res_q <= '0;
      vld_q <= 1'b0;
      tido_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      op_q <= op_d;
      tid_q <= tid_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      fold_q <= fold_d;
      spec_q <= spec_d;
      unsup_q <= unsup_d;
      sres_q <= sres_d;
      res_q <= res_d;
      vld_q <= vld_d;
      tido_q <= tido_d;
    end
  end

  assign result_o = res_q;
  assign cordic_valid_o = vld_q;
  assign cordic_ready_o = (state_q == IDLE);
  assign cordic_trans_id_o = tido_q;

endmodule

// File: tb/tb_cordic_unit.sv
// Directed bench for cordic_unit: sin/cos values, specials,
// busy-ignore, flush and unsupported-op behaviour.
module tb_cordic_unit;
  import cordic_pkg::*;

  localparam real TOL = 1.0 / 16384.0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic vld_i = 1'b0;
  fu_data_t fu = '0;
  logic [63:0] res;
  logic vld_o;
  logic rdy;
  logic [2:0] tid_o;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  cordic_unit dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .fu_data_i        (fu),
    .cordic_valid_i   (vld_i),
    .result_o         (res),
    .cordic_valid_o   (vld_o),
    .cordic_ready_o   (rdy),
    .cordic_trans_id_o(tid_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] b);
    real m;
    int e;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    if (b[30:23] == 8'd0) m = 0.0;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  task automatic chk_tol(input string tag, input logic [63:0] obs,
                         input real want);
    real r;
    real d;
    logic ok;
    r = f2r(obs[31:0]);
    d = r - want;
    if (d < 0.0) d = -d;
    ok = (d <= TOL) && (obs[63:32] == 32'hFFFF_FFFF);
    ncmp++;
    assert (ok === 1'b1) else begin
      nfail++;
      $error("FAIL %s: got %h (%f) want %f +/- 2^-14",
             tag, obs, r, want);
    end
  endtask

  task automatic send(input fu_op op, input logic [31:0] a,
                      input logic [2:0] tid);
    fu.operation = op;
    fu.operand_a = {32'hFFFF_FFFF, a};
    fu.trans_id = tid;
    vld_i = 1'b1;
    @(posedge clk);
    #1;
    vld_i = 1'b0;
  endtask

  task automatic wait_res(output logic [63:0] r, output logic [2:0] t,
                          output int lat);
    lat = 0;
    r = '0;
    t = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (vld_o) begin
        lat = n;
        r = res;
        t = tid_o;
        break;
      end
    end
  endtask

  task automatic op_run(input string tag, input fu_op op,
                        input logic [31:0] a, input logic [2:0] tid,
                        output logic [63:0] r);
    logic [2:0] t;
    int lat;
    send(op, a, tid);
    wait_res(r, t, lat);
    chk({tag, " lat"}, 64'(lat), 64'd6);
    chk({tag, " tid"}, 64'(t), 64'(tid));
    @(posedge clk);
    #1;
    chk({tag, " pulse"}, 64'(vld_o), 64'd0);
  endtask

  task automatic count_vld(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (vld_o) n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic [2:0] t;
    int lat;
    int n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst rdy", 64'(rdy), 64'd1);
    chk("rst vld", 64'(vld_o), 64'd0);
    chk("rst res", res, 64'd0);
    chk("rst tid", 64'(tid_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post rst rdy", 64'(rdy), 64'd1);
    chk("post rst vld", 64'(vld_o), 64'd0);

    op_run("cos-0.5", COS, 32'hBF00_0000, 3'd1, r);
    chk_tol("cos-0.5 val", r, 0.8775825619);
    chk("cos-0.5 rdy", 64'(rdy), 64'd1);

    op_run("sin pi/6", SIN, 32'h3F06_0A92, 3'd2, r);
    chk_tol("sin pi/6 val", r, 0.5);

    op_run("sin pi", SIN, 32'h4049_0FDB, 3'd3, r);
    chk_tol("sin pi val", r, 0.0);

    op_run("cos pi/2", COS, 32'h3FC9_0FDB, 3'd4, r);
    chk_tol("cos pi/2 val", r, 0.0);

    op_run("cos 2", COS, 32'h4000_0000, 3'd5, r);
    chk_tol("cos 2 val", r, -0.4161468365);

    op_run("sin -1", SIN, 32'hBF80_0000, 3'd6, r);
    chk_tol("sin -1 val", r, -0.8414709848);

    op_run("cos -0", COS, 32'h8000_0000, 3'd7, r);
    chk("cos -0 val", r, 64'hFFFF_FFFF_3F80_0000);

    op_run("sin -0", SIN, 32'h8000_0000, 3'd0, r);
    chk("sin -0 val", r, 64'hFFFF_FFFF_8000_0000);

    op_run("sin 4", SIN, 32'h4080_0000, 3'd1, r);
    chk("sin 4 val", r, 64'hFFFF_FFFF_7FC0_0000);

    op_run("sin inf", SIN, 32'h7F80_0000, 3'd2, r);
    chk("sin inf val", r, 64'hFFFF_FFFF_7FC0_0000);

    op_run("cos -3.5", COS, 32'hC060_0000, 3'd3, r);
    chk("cos -3.5 val", r, 64'hFFFF_FFFF_7FC0_0000);

    op_run("add", ADD, 32'h3F80_0000, 3'd4, r);
    chk("add val", r, 64'd0);

    send(COS, 32'h0000_0000, 3'd3);
    chk("busy rdy", 64'(rdy), 64'd0);
    fu.operation = SIN;
    fu.operand_a = {32'hFFFF_FFFF, 32'h3F06_0A92};
    fu.trans_id = 3'd4;
    vld_i = 1'b1;
    @(posedge clk);
    #1;
    vld_i = 1'b0;
    wait_res(r, t, lat);
    chk("busy lat", 64'(lat), 64'd5);
    chk("busy tid", 64'(t), 64'd3);
    chk("busy val", r, 64'hFFFF_FFFF_3F80_0000);
    count_vld(12, n);
    chk("busy extra", 64'(n), 64'd0);

    send(SIN, 32'h3F06_0A92, 3'd5);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush rdy", 64'(rdy), 64'd1);
    count_vld(10, n);
    chk("flush vld", 64'(n), 64'd0);
    chk("flush hold", res, 64'hFFFF_FFFF_3F80_0000);
    chk("flush tid hold", 64'(tid_o), 64'd3);

    op_run("post flush", COS, 32'hBF00_0000, 3'd6, r);
    chk_tol("post flush val", r, 0.8775825619);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
